// File: rtl/ib_ctlr.sv
// Inbound H2C AXI-Stream to slotted 128-bit RAM writer with per-packet valid flags and user interrupt.
// Optional macro IB_BYTE_COUNT_EN adds a saturating per-packet byte count on pkt_bytes.
module ib_ctlr #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          SLOT_WORDS = 64,
  parameter int          IRQ_BIT    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  m_axis_h2c_tdata_0,
  input  logic [7:0]   m_axis_h2c_tkeep_0,
  input  logic         m_axis_h2c_tlast_0,
  input  logic         m_axis_h2c_tvalid_0,
  output logic         m_axis_h2c_tready_0,
  output logic         WrEn,
  output logic [31:0]  WrAddr,
  output logic [127:0] WrData,
  output logic [7:0]   DataValid,
  input  logic [7:0]   RamValid,
  output logic [3:0]   usr_irq_req,
  input  logic [3:0]   usr_irq_ack,
  input  logic         msi_enable,
`ifdef IB_BYTE_COUNT_EN
  output logic [15:0]  pkt_bytes,
`endif
  output logic         ovf_err
);

  localparam int WIDX_W = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(SLOT_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RECV, FLUSH, DROP, IRQ} state_t;

  state_t              state, state_nxt;
  logic [2:0]          cur_slot;
  logic [WIDX_W-1:0]   widx;
  logic                hi;
  logic [63:0]         low_half;
  logic                irq_first;
  logic                irq_req;
  logic                beat_acc;
  logic                slot_busy;
  logic [63:0]         beat_masked;
  logic [7:0]          dv_set;
  logic                unused_ack;

  function automatic logic [63:0] mask_beat(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = k[b] ? d[b*8 +: 8] : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] word_addr(input logic [2:0] slot, input logic [WIDX_W-1:0] w);
    return BASE_ADDR + 32'(slot) * 32'(SLOT_WORDS) + 32'(w);
  endfunction

  assign m_axis_h2c_tready_0 = (state == RECV) || (state == DROP);
  assign beat_acc    = m_axis_h2c_tvalid_0 && m_axis_h2c_tready_0;
  assign slot_busy   = DataValid[cur_slot];
  assign beat_masked = mask_beat(m_axis_h2c_tdata_0, m_axis_h2c_tkeep_0);
  assign dv_set      = (state == IRQ && irq_first) ? (8'h01 << cur_slot) : 8'h00;
  assign unused_ack  = ^usr_irq_ack;

  always_comb begin
    usr_irq_req          = 4'h0;
    usr_irq_req[IRQ_BIT] = irq_req;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!slot_busy) state_nxt = RECV;
      RECV: begin
        if (beat_acc) begin
          if (!hi && m_axis_h2c_tlast_0)        state_nxt = FLUSH;
          else if (hi && m_axis_h2c_tlast_0)    state_nxt = IRQ;
          else if (hi && widx == WIDX_LAST)     state_nxt = DROP;
        end
      end
      FLUSH: state_nxt = IRQ;
      DROP:  if (beat_acc && m_axis_h2c_tlast_0) state_nxt = IRQ;
      IRQ: begin
        if (irq_first) begin
          if (!msi_enable) state_nxt = IDLE;
        end else if (usr_irq_ack[IRQ_BIT]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write stage: a completed word is presented to the RAM one clock after its high beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_slot  <= 3'd0;
      widx      <= '0;
      hi        <= 1'b0;
      low_half  <= 64'h0;
      irq_first <= 1'b0;
      irq_req   <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= BASE_ADDR;
      WrData    <= 128'h0;
      DataValid <= 8'h00;
      ovf_err   <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      irq_first <= (state_nxt == IRQ) && (state != IRQ);
      // Set wins over a same-cycle release
      DataValid <= (DataValid & ~RamValid) | dv_set;
      case (state)
        IDLE: begin
          if (!slot_busy) begin
            widx <= '0;
            hi   <= 1'b0;
          end
        end
        RECV: begin
          if (beat_acc) begin
            if (!hi) begin
              low_half <= beat_masked;
              hi       <= 1'b1;
            end else begin
              WrEn   <= 1'b1;
              WrData <= {beat_masked, low_half};
              WrAddr <= word_addr(cur_slot, widx);
              widx   <= widx + 1'b1;
              hi     <= 1'b0;
              if (!m_axis_h2c_tlast_0 && widx == WIDX_LAST) ovf_err <= 1'b1;
            end
          end
        end
        FLUSH: begin
          WrEn   <= 1'b1;
          WrData <= {64'h0, low_half};
          WrAddr <= word_addr(cur_slot, widx);
        end
        IRQ: begin
          if (irq_first) begin
            cur_slot <= cur_slot + 3'd1;
            irq_req  <= msi_enable;
          end else if (usr_irq_ack[IRQ_BIT]) begin
            irq_req  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IB_BYTE_COUNT_EN
  logic [15:0] byte_acc;

  function automatic logic [3:0] keep_count(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int b = 0; b < 8; b++) c = c + {3'd0, k[b]};
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_acc  <= 16'h0;
      pkt_bytes <= 16'h0;
    end else begin
      if (state == IDLE)  byte_acc <= 16'h0;
      else if (beat_acc)  byte_acc <= sat_add(byte_acc, keep_count(m_axis_h2c_tkeep_0));
      if (state == IRQ && irq_first) pkt_bytes <= byte_acc;
    end
  end
`endif

endmodule

// File: tb/tb_ib_ctlr.sv
// Randomized self-checking bench for ib_ctlr against a packet-level reference model.
module tb_ib_ctlr;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast, tvalid, tready;
  logic         WrEn;
  logic [31:0]  WrAddr;
  logic [127:0] WrData;
  logic [7:0]   DataValid, RamValid;
  logic [3:0]   usr_irq_req, usr_irq_ack;
  logic         msi_enable, ovf_err;
`ifdef IB_BYTE_COUNT_EN
  logic [15:0]  pkt_bytes;
`endif

  ib_ctlr #(.BASE_ADDR(BASE), .SLOT_WORDS(SW), .IRQ_BIT(0)) dut (
    .clk(clk), .rst(rst),
    .m_axis_h2c_tdata_0(tdata), .m_axis_h2c_tkeep_0(tkeep), .m_axis_h2c_tlast_0(tlast),
    .m_axis_h2c_tvalid_0(tvalid), .m_axis_h2c_tready_0(tready),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .DataValid(DataValid), .RamValid(RamValid),
    .usr_irq_req(usr_irq_req), .usr_irq_ack(usr_irq_ack), .msi_enable(msi_enable),
`ifdef IB_BYTE_COUNT_EN
    .pkt_bytes(pkt_bytes),
`endif
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [127:0] data; logic [31:0] cyc; } wr_t;
  wr_t          wr_q[$];
  int           acc_cyc[$];
  int           cyc = 0;
  int           irq_seen = 0;
  int           total = 0, bad = 0;
  int           exp_slot = 0;
  logic [63:0]  bd[$];
  logic [7:0]   bk[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && tvalid && tready) acc_cyc.push_back(cyc);
    if (WrEn) wr_q.push_back('{WrAddr, WrData, 32'(cyc)});
    if (usr_irq_req != 4'h0) irq_seen++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: packet-level view of what the RAM should receive
  function automatic logic [7:0] kfn(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [63:0] mask64(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (k[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  function automatic logic [127:0] exp_word(input int k);
    logic [63:0] lo, hi;
    lo = mask64(bd[2*k], bk[2*k]);
    hi = (2*k + 1 < bd.size()) ? mask64(bd[2*k+1], bk[2*k+1]) : 64'h0;
    return {hi, lo};
  endfunction

  function automatic int exp_nwords();
    int w;
    w = (bd.size() + 1) / 2;
    return (w > SW) ? SW : w;
  endfunction

  function automatic int exp_bytes();
    int s;
    s = 0;
    foreach (bk[i]) s += $countones(bk[i]);
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic make_pkt(input int n, input int lastb, input bit rnd);
    bd.delete(); bk.delete();
    for (int i = 0; i < n; i++) begin
      bd.push_back({$urandom, $urandom});
      bk.push_back((i == n-1) ? kfn(lastb) : (rnd ? kfn(int'($urandom_range(8, 0))) : 8'hFF));
    end
    wr_q.delete(); acc_cyc.delete();
  endtask

  task automatic drive_pkt(input int gap_max);
    for (int i = 0; i < bd.size(); i++) begin
      int t;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin tvalid = 1'b0; @(posedge clk); #1; end
      tdata = bd[i]; tkeep = bk[i]; tlast = (i == bd.size() - 1); tvalid = 1'b1; t = 0;
      @(negedge clk);
      while (!tready && t < 200) begin t++; @(negedge clk); end
      if (!tready) begin
        total++; bad++;
        $display("FAIL drive_timeout beat=%0d tready=%b required=1", i, tready);
        tvalid = 1'b0; tlast = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_done(input int slot);
    int t;
    t = 0;
    @(negedge clk);
    while (DataValid[slot] !== 1'b1 && t < 100) begin t++; @(negedge clk); end
    if (DataValid[slot] !== 1'b1) begin
      total++; bad++;
      $display("FAIL done_timeout slot=%0d DataValid=%h required_bit=1", slot, DataValid);
    end
    @(posedge clk); #1;
  endtask

  task automatic release_slots(input logic [7:0] m);
    RamValid = m;
    @(posedge clk); #1;
    RamValid = 8'h00;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (tready !== 1'b0)         begin bad++; $display("FAIL rst_tready got=%b want=0", tready); end
    total++; if (WrEn !== 1'b0)           begin bad++; $display("FAIL rst_wren got=%b want=0", WrEn); end
    total++; if (WrAddr !== BASE)         begin bad++; $display("FAIL rst_wraddr got=%h want=%h", WrAddr, BASE); end
    total++; if (WrData !== 128'h0)       begin bad++; $display("FAIL rst_wrdata got=%h want=0", WrData); end
    total++; if (DataValid !== 8'h00)     begin bad++; $display("FAIL rst_datavalid got=%h want=00", DataValid); end
    total++; if (usr_irq_req !== 4'h0)    begin bad++; $display("FAIL rst_irq got=%b want=0000", usr_irq_req); end
    total++; if (ovf_err !== 1'b0)        begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf_err); end
`ifdef IB_BYTE_COUNT_EN
    total++; if (pkt_bytes !== 16'h0)     begin bad++; $display("FAIL rst_bytes got=%0d want=0", pkt_bytes); end
`endif
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int t, d;
    msi_enable = 1'b1;
    make_pkt(4, 8, 0);
    drive_pkt(0);
    t = 0;
    @(negedge clk);
    while (usr_irq_req === 4'h0 && t < 20) begin t++; @(negedge clk); end
    total++; if (usr_irq_req !== 4'b0001) begin bad++; $display("FAIL basic_irq_req got=%b want=0001", usr_irq_req); end
    d = $urandom_range(4, 1);
    repeat (d) begin
      @(negedge clk);
      total++; if (usr_irq_req !== 4'b0001) begin bad++; $display("FAIL basic_irq_hold got=%b want=0001", usr_irq_req); end
    end
    @(posedge clk); #1 usr_irq_ack = 4'b0001;
    @(negedge clk);
    total++; if (usr_irq_req !== 4'b0001) begin bad++; $display("FAIL basic_irq_preack got=%b want=0001", usr_irq_req); end
    @(posedge clk); #1 usr_irq_ack = 4'b0000;
    @(negedge clk);
    total++; if (usr_irq_req !== 4'b0000) begin bad++; $display("FAIL basic_irq_drop got=%b want=0000", usr_irq_req); end
    total++; if (DataValid !== 8'h01)     begin bad++; $display("FAIL basic_datavalid got=%h want=01", DataValid); end
    total++; if (wr_q.size() != 2)        begin bad++; $display("FAIL basic_nwrites got=%0d want=2", wr_q.size()); end
    for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
      total++; if (wr_q[k].addr !== BASE + k) begin bad++; $display("FAIL basic_addr%0d got=%h want=%h", k, wr_q[k].addr, BASE + k); end
      total++; if (wr_q[k].data !== {bd[2*k+1], bd[2*k]}) begin bad++; $display("FAIL basic_data%0d got=%h want=%h", k, wr_q[k].data, {bd[2*k+1], bd[2*k]}); end
      total++; if (acc_cyc.size() == 4 && wr_q[k].cyc != acc_cyc[2*k+1] + 1) begin bad++; $display("FAIL basic_latency%0d got=%0d want=%0d", k, wr_q[k].cyc, acc_cyc[2*k+1] + 1); end
    end
    exp_slot = 1;
    msi_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    irq_seen = 0;
    make_pkt(3, 4, 0);
    drive_pkt(0);
    wait_done(exp_slot);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL flush_nwrites got=%0d want=2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      total++; if (wr_q[0].data !== {bd[1], bd[0]}) begin bad++; $display("FAIL flush_w0 got=%h want=%h", wr_q[0].data, {bd[1], bd[0]}); end
      total++; if (wr_q[1].data !== {64'h0, 32'h0, bd[2][31:0]}) begin bad++; $display("FAIL flush_w1 got=%h want=%h", wr_q[1].data, {64'h0, 32'h0, bd[2][31:0]}); end
      total++; if (wr_q[1].addr !== BASE + SW + 1) begin bad++; $display("FAIL flush_addr got=%h want=%h", wr_q[1].addr, BASE + SW + 1); end
      total++; if (acc_cyc.size() == 3 && wr_q[1].cyc != acc_cyc[2] + 2) begin bad++; $display("FAIL flush_latency got=%0d want=%0d", wr_q[1].cyc, acc_cyc[2] + 2); end
    end
    exp_slot = 2;
    make_pkt(1, 0, 0);
    drive_pkt(0);
    wait_done(exp_slot);
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL zlen_nwrites got=%0d want=1", wr_q.size()); end
    if (wr_q.size() == 1) begin
      total++; if (wr_q[0].data !== 128'h0 || wr_q[0].addr !== BASE + 2*SW) begin bad++; $display("FAIL zlen_write got=%h@%h want=0@%h", wr_q[0].data, wr_q[0].addr, BASE + 2*SW); end
    end
    total++; if (DataValid !== 8'h07) begin bad++; $display("FAIL flush_datavalid got=%h want=07", DataValid); end
    total++; if (irq_seen != 0) begin bad++; $display("FAIL flush_noirq got=%0d want=0", irq_seen); end
    exp_slot = 3;
  endtask

  task automatic test_set_priority();
    int slot, t;
    slot = exp_slot; t = 0;
    RamValid = 8'h01 << slot;
    make_pkt(2, 8, 0);
    drive_pkt(0);
    @(negedge clk);
    while (DataValid[slot] !== 1'b1 && t < 30) begin t++; @(negedge clk); end
    RamValid = 8'h00;
    total++; if (DataValid !== 8'h0F) begin bad++; $display("FAIL prio_set got=%h want=0F", DataValid); end
    @(posedge clk); #1;
    release_slots(8'h02);
    @(negedge clk);
    total++; if (DataValid !== 8'h0D) begin bad++; $display("FAIL prio_release got=%h want=0D", DataValid); end
    @(posedge clk); #1;
    release_slots(8'hFF);
    @(negedge clk);
    total++; if (DataValid !== 8'h00) begin bad++; $display("FAIL prio_clear_all got=%h want=00", DataValid); end
    @(posedge clk); #1;
    exp_slot = 4;
  endtask

  task automatic test_overflow();
    make_pkt(12, 8, 0);
    drive_pkt(1);
    wait_done(exp_slot);
    total++; if (acc_cyc.size() != 12) begin bad++; $display("FAIL ovf_accepted got=%0d want=12", acc_cyc.size()); end
    total++; if (wr_q.size() != SW)    begin bad++; $display("FAIL ovf_nwrites got=%0d want=%0d", wr_q.size(), SW); end
    for (int k = 0; k < SW && k < wr_q.size(); k++) begin
      total++; if (wr_q[k].addr !== BASE + exp_slot*SW + k || wr_q[k].data !== exp_word(k)) begin
        bad++; $display("FAIL ovf_word%0d got=%h@%h want=%h@%h", k, wr_q[k].data, wr_q[k].addr, exp_word(k), BASE + exp_slot*SW + k);
      end
    end
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf_err); end
`ifdef IB_BYTE_COUNT_EN
    total++; if (pkt_bytes !== 16'd96) begin bad++; $display("FAIL ovf_bytes got=%0d want=96", pkt_bytes); end
`endif
    release_slots(8'h01 << exp_slot);
    exp_slot = 5;
  endtask

  task automatic test_back_to_back();
    irq_seen = 0;
    make_pkt(2, 8, 0);
    drive_pkt(0);
    for (int i = 0; i < 2; i++) begin bd.push_back({$urandom, $urandom}); bk.push_back(8'hFF); end
    bd.delete(0); bd.delete(0); bk.delete(0); bk.delete(0);
    drive_pkt(0);
    wait_done(exp_slot + 1);
    total++; if (acc_cyc.size() == 4 && acc_cyc[2] - acc_cyc[1] != 3) begin bad++; $display("FAIL b2b_gap got=%0d want=3", acc_cyc[2] - acc_cyc[1]); end
    total++; if (wr_q.size() != 2 || wr_q[1].addr !== BASE + (exp_slot + 1)*SW || wr_q[1].data !== {bd[1], bd[0]}) begin
      bad++; $display("FAIL b2b_second nwr=%0d addr=%h want_addr=%h", wr_q.size(), (wr_q.size() > 1) ? wr_q[1].addr : 32'h0, BASE + (exp_slot + 1)*SW);
    end
    total++; if (irq_seen != 0) begin bad++; $display("FAIL b2b_noirq got=%0d want=0", irq_seen); end
    release_slots(8'h03 << exp_slot);
    exp_slot = 7;
  endtask

  task automatic test_random();
    for (int p = 0; p < 17; p++) begin
      int n, slot, nw;
      n = $urandom_range(10, 1);
      slot = exp_slot;
      make_pkt(n, $urandom_range(8, 0), 1);
      drive_pkt(2);
      wait_done(slot);
      nw = exp_nwords();
      total++; if (wr_q.size() != nw) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d want=%0d", p, wr_q.size(), nw); end
      for (int k = 0; k < nw && k < wr_q.size(); k++) begin
        total++; if (wr_q[k].addr !== BASE + slot*SW + k || wr_q[k].data !== exp_word(k)) begin
          bad++; $display("FAIL rnd%0d_word%0d got=%h@%h want=%h@%h", p, k, wr_q[k].data, wr_q[k].addr, exp_word(k), BASE + slot*SW + k);
        end
      end
`ifdef IB_BYTE_COUNT_EN
      total++; if (pkt_bytes !== 16'(exp_bytes())) begin bad++; $display("FAIL rnd%0d_bytes got=%0d want=%0d", p, pkt_bytes, exp_bytes()); end
`endif
      total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL rnd%0d_ovf_sticky got=%b want=1", p, ovf_err); end
      exp_slot = (exp_slot + 1) % 8;
      release_slots(8'h01 << slot);
    end
  endtask

  task automatic test_full();
    release_slots(8'hFF);
    for (int p = 0; p < 8; p++) begin
      make_pkt(2, 8, 0);
      drive_pkt(0);
      wait_done(exp_slot);
      exp_slot = (exp_slot + 1) % 8;
    end
    total++; if (DataValid !== 8'hFF) begin bad++; $display("FAIL full_datavalid got=%h want=FF", DataValid); end
    make_pkt(2, 8, 0);
    fork
      drive_pkt(0);
      begin
        repeat (10) begin
          @(negedge clk);
          total++; if (tready !== 1'b0) begin bad++; $display("FAIL full_stall_tready got=%b want=0", tready); end
        end
        total++; if (acc_cyc.size() != 0) begin bad++; $display("FAIL full_stall_accepted got=%0d want=0", acc_cyc.size()); end
        @(posedge clk); #1;
        release_slots(8'h01 << exp_slot);
      end
    join
    wait_done(exp_slot);
    total++; if (wr_q.size() != 1 || wr_q[0].addr !== BASE + exp_slot*SW || wr_q[0].data !== {bd[1], bd[0]}) begin
      bad++; $display("FAIL full_wrap nwr=%0d addr=%h want_addr=%h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 32'h0, BASE + exp_slot*SW);
    end
    exp_slot = (exp_slot + 1) % 8;
  endtask

  task automatic test_reset_mid();
    int t;
    t = 0;
    release_slots(8'h01 << exp_slot);
    make_pkt(4, 8, 0);
    tdata = bd[0]; tkeep = bk[0]; tlast = 1'b0; tvalid = 1'b1;
    @(negedge clk);
    while (!tready && t < 50) begin t++; @(negedge clk); end
    @(posedge clk); #1 tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (tready !== 1'b0)      begin bad++; $display("FAIL rmid_tready got=%b want=0", tready); end
    total++; if (WrAddr !== BASE)      begin bad++; $display("FAIL rmid_wraddr got=%h want=%h", WrAddr, BASE); end
    total++; if (WrData !== 128'h0)    begin bad++; $display("FAIL rmid_wrdata got=%h want=0", WrData); end
    total++; if (DataValid !== 8'h00)  begin bad++; $display("FAIL rmid_datavalid got=%h want=00", DataValid); end
    total++; if (ovf_err !== 1'b0)     begin bad++; $display("FAIL rmid_ovf got=%b want=0", ovf_err); end
`ifdef IB_BYTE_COUNT_EN
    total++; if (pkt_bytes !== 16'h0)  begin bad++; $display("FAIL rmid_bytes got=%0d want=0", pkt_bytes); end
`endif
    @(posedge clk); #1 rst = 1'b0;
    exp_slot = 0;
    wr_q.delete(); acc_cyc.delete();
    drive_pkt(0);
    wait_done(0);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL rmid_nwrites got=%0d want=2", wr_q.size()); end
    for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
      total++; if (wr_q[k].addr !== BASE + k || wr_q[k].data !== {bd[2*k+1], bd[2*k]}) begin
        bad++; $display("FAIL rmid_word%0d got=%h@%h want=%h@%h", k, wr_q[k].data, wr_q[k].addr, {bd[2*k+1], bd[2*k]}, BASE + k);
      end
    end
    total++; if (DataValid !== 8'h01) begin bad++; $display("FAIL rmid_datavalid_after got=%h want=01", DataValid); end
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    RamValid = 8'h00; usr_irq_ack = 4'h0; msi_enable = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_set_priority();
    test_overflow();
    test_back_to_back();
    test_random();
    test_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ib_ctlr.md
Name: ib_ctlr

Overview:
- Inbound (host-to-card) counterpart of the outbound controller.
- Accepts the XDMA H2C channel-0 AXI-Stream (64-bit) and packs beats into 128-bit RAM words.
- Writes each packet into one of 8 fixed-size RAM slots and flags the slot valid to the downstream consumer.
- Raises a user interrupt per completed packet.

Parameters:
- BASE_ADDR, 32'h0000_0000, RAM word address of slot 0.
- SLOT_WORDS, 64, number of 128-bit words per slot; power of two, 2..4096.
- IRQ_BIT, 0, index into usr_irq_req/usr_irq_ack used for packet-done interrupts.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous reset, active-high
- m_axis_h2c_tdata_0  in  64  H2C stream data
- m_axis_h2c_tkeep_0  in  8  byte enables; contiguous from bit 0
- m_axis_h2c_tlast_0  in  1  last beat of packet
- m_axis_h2c_tvalid_0  in  1  beat valid
- m_axis_h2c_tready_0  out  1  beat accepted when tvalid & tready
- WrEn  out  1  RAM write strobe
- WrAddr  out  32  RAM word address
- WrData  out  128  RAM write data
- DataValid  out  8  per-slot "filled" flags
- RamValid  in  8  per-slot release pulses from consumer; clears DataValid[i]
- usr_irq_req  out  4  XDMA user interrupt request
- usr_irq_ack  in  4  XDMA user interrupt acknowledge
- msi_enable  in  1  interrupts permitted
- ovf_err  out  1  sticky: packet exceeded slot capacity

Behaviour:
- Reset values: tready=0, WrEn=0, WrAddr=BASE_ADDR, WrData=0, DataValid=0, usr_irq_req=0, ovf_err=0.
- Internal state: slot pointer cur_slot (3-bit, reset 0), word index widx, half flag hi, 64-bit low-half holding register.
- FSM states: IDLE, RECV, FLUSH, DROP, IRQ. Reset state is IDLE.
- IDLE:
  - If DataValid[cur_slot]=0, go to RECV and clear widx and hi.
  - Otherwise stay in IDLE with tready=0.
  - Slots are filled strictly in order 0..7 and the pointer wraps 7->0.
- RECV: tready=1.
  - Each accepted beat is masked by tkeep: bytes with tkeep=0 are written as 8'h00.
  - hi=0 beat: store it as the low half and set hi=1.
  - hi=1 beat: on the next cycle drive WrEn=1, WrData={beat,low_half}, WrAddr=BASE_ADDR + cur_slot*SLOT_WORDS + widx. Then widx+1 and hi=0.
  - Write latency: 1 clk after acceptance of the high-half beat.
  - tlast on a hi=1 beat: final write as above, then go to IRQ.
  - tlast on a hi=0 beat: go to FLUSH.
  - Non-last high-half beat completing word SLOT_WORDS-1: set ovf_err=1 and go to DROP.
- FLUSH:
  - tready=0.
  - One write of {64'h0, low_half} at the current widx, then go to IRQ.
- DROP:
  - tready=1; beats are discarded with no writes until an accepted tlast, then go to IRQ.
  - The truncated slot still completes and is flagged.
- IRQ:
  - tready=0.
  - In the first IRQ cycle set DataValid[cur_slot]=1 and increment cur_slot mod 8.
  - If msi_enable=1: assert usr_irq_req[IRQ_BIT] and hold it until usr_irq_ack[IRQ_BIT]=1 is sampled. Deassert in the cycle after the ack, then go to IDLE.
  - If msi_enable=0: go to IDLE the next cycle with no request.
  - Other usr_irq_req bits are tied 0.
- DataValid[i]:
  - Cleared by RamValid[i]=1.
  - Set takes priority if both occur in the same cycle.
  - RamValid on a clear slot has no effect.
- Back-pressure: tready is never asserted while the target slot is still valid, so the host stalls in IDLE.
- Zero-length packet (single beat with tkeep=0, tlast=1): one word of all-zero data is written and the slot is flagged.
- Reset mid-packet: all state is cleared; the partial packet is lost and nothing is flagged.
- ovf_err is cleared only by rst.

Optional Feature:
- Macro: IB_BYTE_COUNT_EN.
- Defined:
  - Adds output port pkt_bytes (16-bit, reset 0) and a per-packet byte accumulator.
  - The accumulator sums popcount(tkeep) over accepted beats, including beats dropped in DROP; it saturates at 16'hFFFF.
  - pkt_bytes is updated in the first IRQ cycle and held until the next packet's IRQ.
- Undefined: neither the port nor the accumulator exists; all other behaviour is identical.

Test Plan:
- 4-beat packet, tkeep=FF, into slot 0 -> 2 writes at BASE_ADDR+0 and +1, each 1 clk after its high beat; DataValid=8'h01; usr_irq_req[0] high until ack.
- 3-beat packet, last beat tkeep=8'h0F -> word 1 = {64'h0, 32'h0, low 32 bits of beat 2}, written via FLUSH; DataValid bit set.
- All 8 slots filled with RamValid held 0 -> 9th packet sees tready=0 and waits in IDLE. RamValid[0] pulse -> packet lands at BASE_ADDR+0 (pointer wrapped).
- SLOT_WORDS=4, 12-beat packet -> 4 writes, ovf_err=1, beats 9-12 accepted and not written; slot flagged. With IB_BYTE_COUNT_EN, pkt_bytes=96.
- msi_enable=0 -> no usr_irq_req; IRQ lasts 1 clk; the next packet starts with no gap beyond IDLE.
- rst asserted after beat 1 of 4 -> all outputs return to reset values immediately. A new packet is written to slot 0, widx 0.
